// File: rtl/mem_arbiter.sv
// Unified 256 B memory arbiter: instruction fetch vs load/store, req/gnt/rvalid handshake.
// Build option: define MEM_ARB_MISALIGN_CHECK_EN to trap misaligned data accesses (d_err).
module mem_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_BASE  = 127,
   parameter int MAX_STREAK = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [31:0]       if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [2:0]        d_funct3,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [2:0]        mem_funct3,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              busy
);
   localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RESP_IF = 2'd1;
   localparam logic [1:0] S_RESP_D  = 2'd2;

   logic [1:0]        r_state;
   logic [SW-1:0]     r_streak;
   logic              r_we;
   logic              r_err;
   logic              w_idle;
   logic              w_force_if;
   logic              w_gnt_if;
   logic              w_gnt_d;
   logic              w_misalign;
   logic [ADDR_W-1:0] w_d_addr;

   // Grants are gated by rst_n so every output reads 0 while reset is held.
   assign w_idle     = rst_n && (r_state == S_IDLE);
   assign w_force_if = (r_streak == SW'(MAX_STREAK));
   assign w_gnt_if   = w_idle && if_req && (!d_req || w_force_if);
   assign w_gnt_d    = w_idle && d_req && !w_gnt_if;
   assign w_d_addr   = d_addr + ADDR_W'(DATA_BASE);

`ifdef MEM_ARB_MISALIGN_CHECK_EN
   assign w_misalign = (((d_funct3 == 3'b001) || (d_funct3 == 3'b101)) && d_addr[0]) ||
                       ((d_funct3 == 3'b010) && (d_addr[1:0] != 2'b00));
   assign d_err      = (r_state == S_RESP_D) && r_err;
`else
   assign w_misalign = 1'b0;
   assign d_err      = 1'b0;
`endif

   assign if_gnt    = w_gnt_if;
   assign d_gnt     = w_gnt_d;
   assign if_rvalid = (r_state == S_RESP_IF);
   assign d_rvalid  = (r_state == S_RESP_D);
   assign if_rdata  = if_rvalid ? mem_rdata : 32'd0;
   assign d_rdata   = (d_rvalid && !r_we && !r_err) ? mem_rdata : 32'd0;
   assign busy      = (r_state != S_IDLE);

   always_comb begin
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_funct3 = 3'b000;
      mem_addr   = '0;
      mem_wdata  = 32'd0;
      if (w_gnt_if) begin
         mem_en     = 1'b1;
         mem_funct3 = 3'b010;
         mem_addr   = if_addr;
      end else if (w_gnt_d && !w_misalign) begin
         mem_en     = 1'b1;
         mem_we     = d_we;
         mem_funct3 = d_funct3;
         mem_addr   = w_d_addr;
         mem_wdata  = d_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_gnt_if) begin
                  r_state <= S_RESP_IF;
               end else if (w_gnt_d) begin
                  r_state <= S_RESP_D;
                  r_we    <= d_we;
                  r_err   <= w_misalign;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Streak counts data wins over a waiting fetch; a fetch win or idle fetch side clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_streak <= '0;
      end else if (!if_req || w_gnt_if) begin
         r_streak <= '0;
      end else if (w_gnt_d && !w_force_if) begin
         r_streak <= r_streak + SW'(1);
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-memory emulator plus a transaction-level reference model.
module tb_mem_arbiter;
   localparam int MAXS = 3;

   logic        clk;
   logic        rst_n;
   logic        if_req, if_gnt, if_rvalid;
   logic [7:0]  if_addr;
   logic [31:0] if_rdata;
   logic        d_req, d_we, d_gnt, d_rvalid, d_err;
   logic [2:0]  d_funct3;
   logic [7:0]  d_addr;
   logic [31:0] d_wdata, d_rdata;
   logic        mem_en, mem_we, busy;
   logic [2:0]  mem_funct3;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   logic [7:0]  emem [256];
   logic [7:0]  ref_mem [256];
   logic        pl_en;
   logic [7:0]  pl_a, pl_d;

   int          m_pend;
   logic [31:0] m_rdata;
   logic        m_err;
   int          m_streak;
   logic        m_gif, m_gd;
   logic        obs_if_gnt, obs_d_gnt;
   logic [31:0] obs_if_rdata, obs_d_rdata;
   logic [7:0]  seq;
   logic        rq_ir, rq_dr, rq_dw;
   logic [7:0]  rq_ia, rq_da;
   logic [2:0]  rq_df;
   logic [31:0] rq_wd;

   mem_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_funct3(d_funct3), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_en(mem_en), .mem_we(mem_we), .mem_funct3(mem_funct3), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3);
      case (f3)
         3'b000:  return {{24{w[7]}}, w[7:0]};
         3'b001:  return {{16{w[15]}}, w[15:0]};
         3'b010:  return w;
         3'b100:  return {24'd0, w[7:0]};
         3'b101:  return {16'd0, w[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   function automatic int nbytes(input logic [2:0] f3);
      case (f3)
         3'b000:  return 1;
         3'b001:  return 2;
         3'b010:  return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] eword(input logic [7:0] a);
      return {emem[a + 8'd3], emem[a + 8'd2], emem[a + 8'd1], emem[a]};
   endfunction

   function automatic logic [31:0] rword(input logic [7:0] a);
      return {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
   endfunction

   // Memory array with a registered one-cycle read; also serves as the backdoor loader.
   always @(posedge clk) begin
      if (pl_en) begin
         emem[pl_a] <= pl_d;
      end else if (mem_en) begin
         if (mem_we)
            for (int k = 0; k < nbytes(mem_funct3); k++)
               emem[8'(mem_addr + 8'(k))] <= mem_wdata[8*k +: 8];
         mem_rdata <= extract(eword(mem_addr), mem_funct3);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_if_gnt"},    32'(if_gnt),     32'd0);
      chk({tag, "_if_rvalid"}, 32'(if_rvalid),  32'd0);
      chk({tag, "_if_rdata"},  if_rdata,        32'd0);
      chk({tag, "_d_gnt"},     32'(d_gnt),      32'd0);
      chk({tag, "_d_rvalid"},  32'(d_rvalid),   32'd0);
      chk({tag, "_d_rdata"},   d_rdata,         32'd0);
      chk({tag, "_d_err"},     32'(d_err),      32'd0);
      chk({tag, "_mem_en"},    32'(mem_en),     32'd0);
      chk({tag, "_mem_we"},    32'(mem_we),     32'd0);
      chk({tag, "_mem_f3"},    32'(mem_funct3), 32'd0);
      chk({tag, "_mem_addr"},  32'(mem_addr),   32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata,       32'd0);
      chk({tag, "_busy"},      32'(busy),       32'd0);
   endtask

   // One clock cycle: drive requests, check against the model, then advance the model.
   task automatic step(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                       input logic [2:0] df, input logic [7:0] da, input logic [31:0] dwd);
      logic       mis;
      logic [7:0] pa;
      if_req = ir; if_addr = ia;
      d_req = dr; d_we = dw; d_funct3 = df; d_addr = da; d_wdata = dwd;
      #2;
      obs_if_gnt = if_gnt; obs_d_gnt = d_gnt;
      obs_if_rdata = if_rdata; obs_d_rdata = d_rdata;
      chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
      chk("if_rdata",  if_rdata, (m_pend == 1) ? m_rdata : 32'd0);
      chk("d_rvalid",  32'(d_rvalid), 32'(m_pend == 2));
      chk("d_rdata",   d_rdata, (m_pend == 2) ? m_rdata : 32'd0);
      chk("d_err",     32'(d_err), 32'((m_pend == 2) && m_err));
      chk("busy",      32'(busy), 32'(m_pend != 0));
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      mis = (((df == 3'b001) || (df == 3'b101)) && da[0]) || ((df == 3'b010) && (da[1:0] != 2'b00));
`else
      mis = 1'b0;
`endif
      pa    = da + 8'd127;
      m_gif = (m_pend == 0) && ir && (!dr || (m_streak == MAXS));
      m_gd  = (m_pend == 0) && dr && !m_gif;
      chk("if_gnt", 32'(if_gnt), 32'(m_gif));
      chk("d_gnt",  32'(d_gnt),  32'(m_gd));
      chk("mem_en", 32'(mem_en), 32'(m_gif || (m_gd && !mis)));
      if (m_gif) begin
         chk("if_mem_addr", 32'(mem_addr), 32'(ia));
         chk("if_mem_we",   32'(mem_we), 32'd0);
         chk("if_mem_f3",   32'(mem_funct3), 32'd2);
      end
      if (m_gd && !mis) begin
         chk("d_mem_addr", 32'(mem_addr), 32'(pa));
         chk("d_mem_we",   32'(mem_we), 32'(dw));
         chk("d_mem_f3",   32'(mem_funct3), 32'(df));
         if (dw) chk("d_mem_wdata", mem_wdata, dwd);
      end
      if (m_gif) begin
         m_pend = 1; m_err = 1'b0; m_rdata = rword(ia);
      end else if (m_gd) begin
         m_pend = 2; m_err = mis;
         if (mis || dw) m_rdata = 32'd0;
         else m_rdata = extract(rword(pa), df);
         if (!mis && dw)
            for (int k = 0; k < nbytes(df); k++) ref_mem[8'(pa + 8'(k))] = dwd[8*k +: 8];
      end else begin
         m_pend = 0;
      end
      if (!ir || m_gif) m_streak = 0;
      else if (m_gd && m_streak < MAXS) m_streak++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; pl_en = 1'b0; pl_a = 8'd0; pl_d = 8'd0;
      if_req = 1'b0; if_addr = 8'd0; d_req = 1'b0; d_we = 1'b0;
      d_funct3 = 3'd0; d_addr = 8'd0; d_wdata = 32'd0;
      m_pend = 0; m_rdata = 32'd0; m_err = 1'b0; m_streak = 0; seq = 8'd0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      ref_mem[8] = 8'h93; ref_mem[9] = 8'h06; ref_mem[10] = 8'hA0; ref_mem[11] = 8'h00;
      ref_mem[131] = 8'd25; ref_mem[132] = 8'd0; ref_mem[133] = 8'd0; ref_mem[134] = 8'd0;
      @(posedge clk); #1;
      pl_en = 1'b1;
      for (int i = 0; i < 256; i++) begin
         pl_a = 8'(i); pl_d = ref_mem[i];
         @(posedge clk); #1;
      end
      pl_en = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk_all_zero("reset");
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle();

      step(1'b1, 8'd8, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
      idle();
      chk("fetch_word", obs_if_rdata, 32'h00A00693);

      step(1'b0, 8'd0, 1'b1, 1'b0, 3'b010, 8'd4, 32'd0);
      idle();
      chk("lw_offset", obs_d_rdata, 32'h00000019);

      step(1'b0, 8'd0, 1'b1, 1'b1, 3'b010, 8'd12, 32'hDEADBEEF);
      idle();
      step(1'b0, 8'd0, 1'b1, 1'b0, 3'b010, 8'd12, 32'd0);
      idle();
      chk("sw_lw", obs_d_rdata, 32'hDEADBEEF);

      step(1'b0, 8'd0, 1'b1, 1'b0, 3'b001, 8'd1, 32'd0);
      idle();

      for (int c = 0; c < 16; c++) begin
         step(1'b1, 8'd20, 1'b1, 1'b0, 3'b010, 8'd0, 32'd0);
         if (obs_if_gnt || obs_d_gnt) seq = {seq[6:0], obs_if_gnt};
      end
      chk("grant_order", 32'(seq), 32'h11);
      idle();

      step(1'b1, 8'd16, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
      step(1'b0, 8'd0, 1'b1, 1'b1, 3'b010, 8'd50, 32'h55AA55AA);
      idle();

      step(1'b0, 8'd0, 1'b1, 1'b1, 3'b010, 8'd40, 32'h11223344);
      rst_n = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_pend = 0; m_streak = 0;
      idle();
      step(1'b0, 8'd0, 1'b1, 1'b0, 3'b010, 8'd40, 32'd0);
      idle();
      chk("store_kept", obs_d_rdata, 32'h11223344);

      rq_ir = 1'b0; rq_dr = 1'b0; rq_dw = 1'b0; rq_ia = 8'd0; rq_da = 8'd0; rq_df = 3'd0; rq_wd = 32'd0;
      for (int n = 0; n < 400; n++) begin
         if (!rq_ir) begin
            if ($urandom_range(2) == 0) begin rq_ir = 1'b1; rq_ia = 8'($urandom); end
         end else if ($urandom_range(19) == 0) rq_ir = 1'b0;
         if (!rq_dr) begin
            if ($urandom_range(1) == 0) begin
               rq_dr = 1'b1; rq_dw = 1'($urandom); rq_da = 8'($urandom); rq_wd = $urandom;
               case ($urandom_range(7))
                  0: rq_df = 3'b000; 1: rq_df = 3'b001; 2: rq_df = 3'b010; 3: rq_df = 3'b100;
                  4: rq_df = 3'b101; 5: rq_df = 3'b010; 6: rq_df = 3'b011; default: rq_df = 3'b110;
               endcase
            end
         end else if ($urandom_range(19) == 0) rq_dr = 1'b0;
         step(rq_ir, rq_ia, rq_dr, rq_dw, rq_df, rq_da, rq_wd);
         if (m_gif) rq_ir = 1'b0;
         if (m_gd) rq_dr = 1'b0;
      end
      idle();
      idle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
